// File: rtl/csa_accum_pkg.sv
// Shared types and derived constants for the carry-save accumulator.
// Chunk count and index width are computed here so top and bench agree.
package csa_accum_pkg;

  typedef enum logic [1:0] {
    ST_ACC     = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUT     = 2'd2
  } state_e;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/csa_row.sv
// One row of 3:2 compressors: three WIDTH-bit vectors in, redundant (carry, sum) out.
// The carry vector is the majority shifted up one place; the top carry falls off (mod 2^WIDTH).
module csa_row #(
  parameter int WIDTH = 180
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [WIDTH-1:0] z_i,
  output logic [WIDTH-1:0] c_o,
  output logic [WIDTH-1:0] s_o
);

  logic [WIDTH-1:0] maj;

  assign s_o = x_i ^ y_i ^ z_i;
  assign maj = (x_i & y_i) | (x_i & z_i) | (y_i & z_i);
  assign c_o = maj << 1;

endmodule

// File: rtl/csa_accum.sv
// Carry-save accumulator: one compressor row per operand, then a chunked
// multi-cycle carry-propagate resolve and a valid/ready result port.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_ACC     | accepting operands into the redundant (sum, carry) pair
//   ST_RESOLVE | adding one CPA_CHUNK slice of sum+carry per cycle
//   ST_OUT     | result presented, waiting for out_ready_i
module csa_accum
  import csa_accum_pkg::*;
#(
  parameter int WIDTH     = 180,
  parameter int CPA_CHUNK = 45
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_first_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_sum_o
);

  localparam int NCHUNK = nchunk(WIDTH, CPA_CHUNK);
  localparam int IDXW   = idx_width(NCHUNK);

  if (WIDTH % CPA_CHUNK != 0) begin : g_bad_chunk
    $error("csa_accum: WIDTH must be a multiple of CPA_CHUNK");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_s_q, acc_s_d;
  logic [WIDTH-1:0] acc_c_q, acc_c_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;

  logic [WIDTH-1:0]   row_s, row_c;
  logic [CPA_CHUNK:0] chunk_sum;
  int                 chunk_lo;

  csa_row #(.WIDTH(WIDTH)) u_row (
    .x_i (acc_s_q),
    .y_i (acc_c_q),
    .z_i (in_data_i),
    .c_o (row_c),
    .s_o (row_s)
  );

  // Bit CPA_CHUNK of the slice sum is the carry into the next slice.
  assign chunk_lo  = int'(idx_q) * CPA_CHUNK;
  assign chunk_sum = {1'b0, acc_s_q[chunk_lo +: CPA_CHUNK]}
                   + {1'b0, acc_c_q[chunk_lo +: CPA_CHUNK]}
                   + {{CPA_CHUNK{1'b0}}, carry_q};

  always_comb begin
    state_d     = state_q;
    acc_s_d     = acc_s_q;
    acc_c_d     = acc_c_q;
    result_d    = result_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      ST_ACC: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          if (in_first_i) begin
            acc_s_d = in_data_i;
            acc_c_d = '0;
          end else begin
            acc_s_d = row_s;
            acc_c_d = row_c;
          end
          if (in_last_i) begin
            state_d = ST_RESOLVE;
            idx_d   = '0;
            carry_d = 1'b0;
          end
        end
      end
      ST_RESOLVE: begin
        result_d[chunk_lo +: CPA_CHUNK] = chunk_sum[CPA_CHUNK-1:0];
        carry_d = chunk_sum[CPA_CHUNK];
        if (idx_q == IDXW'(NCHUNK - 1)) begin
          state_d = ST_OUT;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      ST_OUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = ST_ACC;
          acc_s_d = '0;
          acc_c_d = '0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ACC;
      acc_s_q  <= '0;
      acc_c_q  <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_s_q  <= acc_s_d;
      acc_c_q  <= acc_c_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
    end
  end

  assign out_sum_o = result_q;

endmodule

// File: tb/tb_csa_accum.sv
// Bench for csa_accum: directed literal cases plus random streams checked
// every cycle against a plain-arithmetic model of the accumulate/resolve/output timeline.
module tb_csa_accum;

  localparam int W   = 180;
  localparam int CH  = 45;
  localparam int NCH = W / CH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_first = 1'b0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_sum;

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_or  = 1'b0;

  csa_accum #(.WIDTH(W), .CPA_CHUNK(CH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_first_i  (in_first),
    .in_last_i   (in_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sum_o   (out_sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference timeline: phase 0 accepting, 1 resolving (m_cnt cycles left), 2 presenting.
  int           m_phase;
  int           m_cnt;
  logic [W-1:0] m_acc, m_res, m_last;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_acc   <= '0;
      m_res   <= '0;
      m_last  <= '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          if (in_last) begin
            m_res   <= in_first ? in_data : m_acc + in_data;
            m_acc   <= '0;
            m_phase <= 1;
            m_cnt   <= NCH;
          end else begin
            m_acc <= in_first ? in_data : m_acc + in_data;
          end
        end
        1: begin
          if (m_cnt == 1) m_phase <= 2;
          m_cnt <= m_cnt - 1;
        end
        default: if (out_ready) begin
          m_last  <= m_res;
          m_phase <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", W'(in_ready), W'(m_phase == 0));
      chk("out_valid", W'(out_valid), W'(m_phase == 2));
      if (m_phase == 2) chk("out_sum_out", out_sum, m_res);
      if (m_phase == 0) chk("out_sum_hold", out_sum, m_last);
    end
  end

  always @(negedge clk) begin
    if (rand_or) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Caller is at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [W-1:0] d, input bit f, input bit l);
    int n;
    bit rdy;
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    in_last  = l;
    n = 0;
    do begin
      rdy = in_ready;
      @(negedge clk);
      n++;
    end while (!rdy && n < 64);
    if (!rdy) chk("send_accept_timeout", W'(rdy), W'(1));
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [W-1:0] exp, output int lat);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_valid"}, W'(out_valid), W'(1));
    chk(name, out_sum, exp);
    chk({name, "_model"}, m_res, exp);
    while (!out_ready && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rnd_data();
    logic [191:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      default: return r[W-1:0];
    endcase
  endfunction

  initial begin
    int lat;
    logic [W-1:0] ones, b45;
    ones = '1;
    b45  = W'(1) << 45;

    repeat (3) @(negedge clk);
    chk("reset_in_ready", W'(in_ready), W'(1));
    chk("reset_out_valid", W'(out_valid), W'(0));
    chk("reset_out_sum", out_sum, '0);
    rst_n = 1'b1;
    @(negedge clk);

    out_ready = 1'b1;
    send(W'(5), 1, 1);
    wait_result("single", W'(5), lat);
    chk("single_latency", W'(lat), W'(5));
    chk("single_ready_back", W'(in_ready), W'(1));

    send(W'(1), 1, 0);
    send(W'(2), 0, 0);
    send(W'(3), 0, 1);
    wait_result("sum123", W'(6), lat);

    send(b45 - W'(1), 1, 0);
    send(W'(1), 0, 1);
    wait_result("chunk_carry", b45, lat);

    send(ones, 1, 0);
    send(W'(1), 0, 1);
    wait_result("wrap", '0, lat);

    out_ready = 1'b0;
    send(W'(10), 1, 0);
    send(W'(20), 0, 1);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b1;
    in_data  = W'(153);
    in_first = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_sum_stable", out_sum, W'(30));
      chk("bp_in_ready", W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_after", W'(in_ready), W'(1));
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    wait_result("bp_next", W'(153), lat);
    chk("bp_next_latency", W'(lat), W'(5));

    send(W'(100), 1, 0);
    send(W'(200), 0, 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_sum", out_sum, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    send(W'(7), 1, 0);
    send(W'(8), 0, 1);
    wait_result("after_reset", W'(15), lat);

    rand_or = 1'b1;
    for (int s = 0; s < 40; s++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        bit f;
        f = (i == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
        send(rnd_data(), f, i == len - 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    rand_or   = 1'b0;
    out_ready = 1'b1;
    repeat (NCH + 4) @(negedge clk);
    chk("final_idle", W'(in_ready), W'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
